// File: rtl/comar_mask_prng.sv
// comar_mask_prng: seeded 64-bit LFSR delivering RAND_WIDTH fresh mask bits per enabled cycle.
// Optional post-seed warm-up (128 discarded advances) is enabled by defining COMAR_PRNG_WARMUP_EN.
module comar_mask_prng #(
  parameter int RAND_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           seed,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic                  en,
  output logic [RAND_WIDTH-1:0] r,
  output logic                  r_valid
);

`ifdef COMAR_PRNG_WARMUP_EN
  typedef enum logic [1:0] {IDLE, LOAD_HI, WARMUP, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD_HI, RUN} state_t;
`endif

  state_t                  r_state;
  logic [63:0]             r_s;
  logic [RAND_WIDTH-1:0]   r_out;
  logic                    r_vld;
  logic                    r_rdy;

  state_t                  w_state_nxt;
  logic [63:0]             w_s_nxt;
  logic [63:0]             w_s_adv;
  logic [63:0]             w_seed_full;
  logic                    w_seed_acc;

`ifdef COMAR_PRNG_WARMUP_EN
  logic [6:0]              r_cnt;
  logic [6:0]              w_cnt_nxt;
`endif

  // RAND_WIDTH unrolled Fibonacci steps, taps 64/63/61/60.
  function automatic logic [63:0] lfsr_advance(input logic [63:0] s_in);
    logic [63:0] s_t;
    s_t = s_in;
    for (int i = 0; i < RAND_WIDTH; i++)
      s_t = {s_t[62:0], s_t[63] ^ s_t[62] ^ s_t[60] ^ s_t[59]};
    return s_t;
  endfunction

  assign w_seed_acc  = seed_valid & r_rdy;
  assign w_s_adv     = lfsr_advance(r_s);
  assign w_seed_full = {seed, r_s[31:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
`ifdef COMAR_PRNG_WARMUP_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_seed_acc) begin
          w_s_nxt     = {r_s[63:32], seed};
          w_state_nxt = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (w_seed_acc) begin
          // An all-zero state would lock the LFSR up forever.
          w_s_nxt = (w_seed_full == 64'h0) ? 64'h1 : w_seed_full;
`ifdef COMAR_PRNG_WARMUP_EN
          w_state_nxt = WARMUP;
          w_cnt_nxt   = 7'd0;
`else
          w_state_nxt = RUN;
`endif
        end
      end
`ifdef COMAR_PRNG_WARMUP_EN
      WARMUP: begin
        w_s_nxt   = w_s_adv;
        w_cnt_nxt = r_cnt + 7'd1;
        if (r_cnt == 7'd127) w_state_nxt = RUN;
      end
`endif
      RUN: begin
        // A reseed word takes priority over en; the high half is kept until replaced.
        if (w_seed_acc) begin
          w_s_nxt     = {r_s[63:32], seed};
          w_state_nxt = LOAD_HI;
        end else if (en) begin
          w_s_nxt = w_s_adv;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= 64'h0;
      r_out   <= '0;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
`ifdef COMAR_PRNG_WARMUP_EN
      r_cnt   <= 7'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_out   <= (w_state_nxt == RUN) ? w_s_nxt[RAND_WIDTH-1:0] : '0;
      r_vld   <= (w_state_nxt == RUN);
`ifdef COMAR_PRNG_WARMUP_EN
      r_rdy   <= (w_state_nxt != WARMUP);
      r_cnt   <= w_cnt_nxt;
`else
      r_rdy   <= 1'b1;
`endif
    end
  end

  assign r          = r_out;
  assign r_valid    = r_vld;
  assign seed_ready = r_rdy;

endmodule

// File: doc/comar_mask_prng.md
# comar_mask_prng

Fresh-mask source for first-order COMAR gadgets (2-share AND, 6 random bits per gadget per cycle). A 64-bit LFSR is seeded over a 32-bit handshake, warmed up, and then delivers RAND_WIDTH fresh bits per enabled cycle on `r`, which drives the gadgets' `r` inputs directly. `r_valid` qualifies the masks; downstream control must not launch gadget operations while it is low.

## Interface
- `RAND_WIDTH`, default 6: mask bits per cycle, legal range 1..64. Use 6 × number of gadgets fed.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `seed` input 32: seed word. The low word is sent first, then the high word.
- `seed_valid` input 1: seed word offered.
- `seed_ready` output 1: seed word accepted when `seed_valid & seed_ready` on a rising edge.
- `en` input 1: advance the generator by one output word. Valid in RUN only.
- `r` output RAND_WIDTH: fresh masks. Equal to `s[RAND_WIDTH-1:0]` in RUN, forced to 0 otherwise.
- `r_valid` output 1: high only in RUN.

## Operation
- **State register `s[63:0]`.**
  - One LFSR step: `fb = s[63]^s[62]^s[60]^s[59]`, then `s <= {s[62:0], fb}`.
  - One advance is RAND_WIDTH consecutive steps, unrolled in a single cycle.
- **FSM states.**
  - IDLE: `seed_ready=1`. An accepted word is latched as `s[31:0]`, then go to LOAD_HI.
  - LOAD_HI: `seed_ready=1`. An accepted word is latched as `s[63:32]`, then go to WARMUP. Without the macro, go directly to RUN.
  - WARMUP: `seed_ready=0`. One advance per cycle regardless of `en`. A 7-bit counter runs 128 cycles, then go to RUN.
  - RUN: `seed_ready=1`, `r_valid=1`.
    - An advance occurs on each cycle with `en=1`.
    - An accepted seed word in RUN starts a reseed: it is latched as `s[31:0]`, `s[63:32]` is held, and the FSM goes to LOAD_HI.
- **All-zero seed.** If the assembled 64-bit seed is 0 at the LOAD_HI acceptance, `s` is loaded with 64'h1 instead.
- **`en` outside RUN** is ignored.
- **`seed_valid` in WARMUP** is ignored. The word stays pending until `seed_ready` rises.
- **Simultaneous `en` and seed acceptance in RUN:** the seed wins and no advance occurs.
- **Reset values:**
  - FSM: IDLE.
  - `s`: 64'h0.
  - Warm-up counter: 0.
  - Outputs: `r=0`, `r_valid=0`, `seed_ready=1`.
- **Reset mid-operation** (any state) returns to IDLE; a half-loaded seed is discarded.

## Timing
- Every output is a function of registered state only; there is no combinational path from inputs to outputs.
- `r_valid` rises the cycle after the final warm-up advance, i.e. 128 cycles after the high word is accepted. Without the macro, it rises the cycle after acceptance.
- In RUN, the new `r` is visible the cycle after an `en=1` edge. With `en=0`, `r` holds.
- `r_valid` falls the cycle after a reseed word is accepted in RUN.
- The gadget consumes `r` in the same cycle it samples its shares, so the upstream controller asserts `en` on every cycle a gadget operation is issued.

## Configuration
- Macro: `COMAR_PRNG_WARMUP_EN`.
- Defined: the WARMUP state and its 7-bit counter exist, and 128 advances are discarded after every (re)seed.
- Undefined: the WARMUP state and counter are removed. LOAD_HI goes straight to RUN, and the first `r` is the seed's low bits.

## Test plan
All scenarios use `RAND_WIDTH=6`. Scenarios 1–3 have the macro undefined; scenario 4 has it defined.
1. Reset, then seed low=32'h0 and high=32'h8000_0000 → `r_valid=1`, `r=6'h00`. Pulse `en` once → `r=6'h20`.
2. Seed low=0, high=0 → `s` forced to 64'h1: `r_valid=1`, `r=6'h01`.
3. RUN with `en=0` for 10 cycles → `r` constant. Then assert `en` and `seed_valid` together → no advance, `r_valid=0` next cycle, FSM in LOAD_HI.
4. Seed as in scenario 1 → `seed_ready=0` and `r=0` for exactly 128 cycles. `r_valid` rises on cycle 129 with `r` matching the reference model after 128 advances.
5. Assert `rst_n=0` asynchronously between the low and high seed words → immediately `r=0`, `r_valid=0`, `seed_ready=1`, FSM in IDLE. A fresh two-word seed then behaves as in scenario 1.
